// File: rtl/first_system_checker.sv
// Response checker for the first_system stimulus sequence: captures each applied
// vector, waits SETTLE clocks, compares the response to EXP_TABLE and keeps a verdict.
module first_system_checker #(
    parameter logic [7:0] EXP_TABLE = 8'h94,
    parameter int         NUM_VEC   = 4,
    parameter int         SETTLE    = 2,
    parameter int         CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [1:0]       vec_in,
    input  logic [1:0]       resp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [1:0]       first_err_vec,
    output logic             first_err_vld,
    output logic             overrun
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] NUM_VEC_C   = CNT_W'(NUM_VEC);
    localparam logic [CNT_W-1:0] ERR_MAX     = '1;

    state_t           state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [1:0]       vec_q, vec_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fe_vec_q, fe_vec_d;
    logic             fe_vld_q, fe_vld_d;
    logic             ovr_q, ovr_d;

    logic             compare_now;
    logic             mismatch;
    logic [1:0]       exp_resp;
    logic [CNT_W-1:0] cnt_inc;

    assign compare_now = (state_q == ST_SETTLE) && (settle_q == '0);
    assign exp_resp    = EXP_TABLE[{vec_q, 1'b0} +: 2];
    assign mismatch    = compare_now && (resp_in != exp_resp);
    assign cnt_inc     = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            vec_q    <= '0;
            err_q    <= '0;
            cnt_q    <= '0;
            fe_vec_q <= '0;
            fe_vld_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            fe_vec_q <= fe_vec_d;
            fe_vld_q <= fe_vld_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_ARMED;
            ST_ARMED:         if (vec_valid) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (compare_now) state_d = (cnt_inc == NUM_VEC_C) ? ST_DONE : ST_ARMED;
            end
            default:          state_d = ST_IDLE;
        endcase
    end

    // Counters and first-error capture; start clears the verdict only outside a run.
    always_comb begin
        settle_d = settle_q;
        vec_d    = vec_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        fe_vec_d = fe_vec_q;
        fe_vld_d = fe_vld_q;
        ovr_d    = ovr_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_d    = '0;
                    cnt_d    = '0;
                    fe_vec_d = '0;
                    fe_vld_d = 1'b0;
                    ovr_d    = 1'b0;
                end
            end
            ST_ARMED: begin
                if (vec_valid) begin
                    vec_d    = vec_in;
                    settle_d = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (vec_valid) ovr_d = 1'b1;
                if (compare_now) begin
                    cnt_d = cnt_inc;
                    if (mismatch) begin
                        err_d = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;
                        if (!fe_vld_q) begin
                            fe_vec_d = vec_q;
                            fe_vld_d = 1'b1;
                        end
                    end
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_ARMED) || (state_q == ST_SETTLE);
        done = (state_q == ST_DONE);
        pass = done && (err_q == '0) && !ovr_q;
    end

    assign err_cnt       = err_q;
    assign vec_cnt       = cnt_q;
    assign first_err_vec = fe_vec_q;
    assign first_err_vld = fe_vld_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_first_system_checker.sv
// Bench for first_system_checker: directed scenarios plus randomized traffic,
// checked against a timestamp-based model of the checking protocol.
module tb_first_system_checker;

    localparam int A_SETTLE = 2;
    localparam int A_NUM    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, vv;
    logic [1:0] vec, resp;
    logic       a_busy, a_done, a_pass, a_fev_vld, a_ovr;
    logic [7:0] a_err, a_cnt;
    logic [1:0] a_fev;

    logic       b_start, b_vv;
    logic [1:0] b_vec, b_resp;
    logic       b_busy, b_done, b_pass, b_fev_vld, b_ovr;
    logic [1:0] b_err, b_cnt;
    logic [1:0] b_fev;

    first_system_checker dut_a (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vv), .vec_in(vec), .resp_in(resp),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_cnt(a_err), .vec_cnt(a_cnt),
        .first_err_vec(a_fev), .first_err_vld(a_fev_vld), .overrun(a_ovr)
    );

    first_system_checker #(.NUM_VEC(3), .SETTLE(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .vec_valid(b_vv), .vec_in(b_vec), .resp_in(b_resp),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err), .vec_cnt(b_cnt),
        .first_err_vec(b_fev), .first_err_vld(b_fev_vld), .overrun(b_ovr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a run is "armed" (waiting for a vector), "pending" (a compare is
    // scheduled at an absolute cycle number) or "done".
    int       cyc = 0;
    int       m_cmp_cyc;
    bit       m_armed, m_pending, m_done, m_fv, m_ovr;
    int       m_err, m_cnt;
    logic [1:0] m_pvec, m_fe;

    function automatic logic [1:0] ha(input logic [1:0] v);
        return {v[1] & v[0], v[1] ^ v[0]};
    endfunction

    function automatic logic [22:0] got_a();
        return {a_busy, a_done, a_pass, a_err, a_cnt, a_fev, a_fev_vld, a_ovr};
    endfunction

    function automatic logic [22:0] exp_a();
        logic mp;
        mp = m_done && (m_err == 0) && !m_ovr;
        return {m_armed || m_pending, m_done, mp, 8'(m_err), 8'(m_cnt), m_fe, m_fv, m_ovr};
    endfunction

    task automatic model_edge(input logic r, s, v, input logic [1:0] vi, ri);
        if (r) begin
            m_armed = 0; m_pending = 0; m_done = 0; m_fv = 0; m_ovr = 0;
            m_err = 0; m_cnt = 0; m_pvec = 0; m_fe = 0;
        end else if (m_pending) begin
            if (v) m_ovr = 1;
            if (cyc == m_cmp_cyc) begin
                m_cnt++;
                if (ri !== ha(m_pvec)) begin
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                    if (!m_fv) begin m_fv = 1; m_fe = m_pvec; end
                end
                m_pending = 0;
                if (m_cnt == A_NUM) m_done = 1; else m_armed = 1;
            end
        end else if (m_armed) begin
            if (v) begin
                m_pvec = vi; m_cmp_cyc = cyc + A_SETTLE; m_pending = 1; m_armed = 0;
            end
        end else if (s) begin
            m_armed = 1; m_done = 0; m_fv = 0; m_ovr = 0; m_err = 0; m_cnt = 0; m_fe = 0;
        end
        cyc++;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic r, s, v, input logic [1:0] vi, ri);
        rst = r; start = s; vv = v; vec = vi; resp = ri;
        @(posedge clk);
        model_edge(r, s, v, vi, ri);
        @(negedge clk);
    endtask

    task automatic apply_vec(input logic [1:0] vi, input logic [1:0] ri, input int gap);
        step(0, 0, 1, vi, ri);
        repeat (gap - 1) step(0, 0, 0, 2'b00, ri);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 2'b11, 0);
        n_tests++;
        if (got_a() !== 23'd0) begin
            n_fail++; $display("FAIL reset_a: got %h required 0", got_a());
        end
        n_tests++;
        if ({b_busy, b_done, b_pass, b_err, b_cnt, b_fev, b_fev_vld, b_ovr} !== 11'd0) begin
            n_fail++; $display("FAIL reset_b: got busy=%b done=%b err=%0d cnt=%0d required 0",
                               b_busy, b_done, b_err, b_cnt);
        end
    endtask

    task automatic test_basic();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) apply_vec(2'(i), ha(2'(i)), 4);
        n_tests++;
        if (got_a() !== exp_a() || a_cnt !== 8'd4 || a_err !== 8'd0 || !a_done || !a_pass || a_fev_vld) begin
            n_fail++; $display("FAIL basic: got %h required %h (cnt=4 err=0 done pass)", got_a(), exp_a());
        end
    endtask

    task automatic test_mismatch();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) apply_vec(2'(i), (i == 2) ? 2'b11 : ha(2'(i)), 4);
        n_tests++;
        if (got_a() !== exp_a() || a_err !== 8'd1 || a_fev !== 2'b10 || !a_fev_vld || a_pass || !a_done) begin
            n_fail++; $display("FAIL mismatch: got %h required %h (err=1 fev=10)", got_a(), exp_a());
        end
    endtask

    task automatic test_overrun();
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 2'b01, ha(2'b01));
        step(0, 0, 1, 2'b11, ha(2'b01));
        step(0, 0, 0, 2'b00, ha(2'b01));
        step(0, 0, 0, 2'b00, ha(2'b01));
        n_tests++;
        if (got_a() !== exp_a() || a_cnt !== 8'd1 || !a_ovr || !a_busy) begin
            n_fail++; $display("FAIL overrun: got %h required %h (cnt=1 ovr=1)", got_a(), exp_a());
        end
        for (int i = 1; i < 4; i++) apply_vec(2'(i), ha(2'(i)), 4);
        n_tests++;
        if (got_a() !== exp_a() || !a_done || a_pass || a_err !== 8'd0) begin
            n_fail++; $display("FAIL overrun_verdict: got %h required %h (done, no pass)", got_a(), exp_a());
        end
    endtask

    task automatic test_midrun_reset();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) apply_vec(2'(i), 2'b11, 4);
        step(1, 0, 0, 0, 0);
        n_tests++;
        if (got_a() !== 23'd0 || exp_a() !== 23'd0) begin
            n_fail++; $display("FAIL midrun_reset: got %h required 0", got_a());
        end
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) apply_vec(2'(3 - i), ha(2'(3 - i)), 3);
        step(0, 0, 0, 0, 0);
        n_tests++;
        if (got_a() !== exp_a() || !a_pass || a_cnt !== 8'd4) begin
            n_fail++; $display("FAIL rerun_after_reset: got %h required %h", got_a(), exp_a());
        end
    endtask

    task automatic test_start_busy();
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 2'b11, 2'b00);
        step(0, 1, 0, 2'b00, 2'b00);
        step(0, 0, 0, 2'b00, 2'b00);
        step(0, 1, 0, 2'b00, 2'b00);
        n_tests++;
        if (got_a() !== exp_a() || a_err !== 8'd1 || a_cnt !== 8'd1 || !a_busy) begin
            n_fail++; $display("FAIL start_while_busy: got %h required %h (err=1 cnt=1)", got_a(), exp_a());
        end
        for (int i = 0; i < 3; i++) apply_vec(2'(i), ha(2'(i)), 4);
        n_tests++;
        if (got_a() !== exp_a() || !a_done || a_pass || a_fev !== 2'b11) begin
            n_fail++; $display("FAIL busy_run_verdict: got %h required %h", got_a(), exp_a());
        end
        step(0, 1, 0, 0, 0);
        n_tests++;
        if (got_a() !== exp_a() || a_err !== 8'd0 || a_cnt !== 8'd0 || a_fev_vld || !a_busy) begin
            n_fail++; $display("FAIL start_clears: got %h required %h", got_a(), exp_a());
        end
        for (int i = 0; i < 4; i++) apply_vec(2'(i), ha(2'(i)), 4);
        n_tests++;
        if (got_a() !== exp_a() || !a_pass) begin
            n_fail++; $display("FAIL clean_after_done: got %h required %h", got_a(), exp_a());
        end
    endtask

    task automatic test_same_edge();
        step(0, 0, 1, 2'b10, 2'b00);
        step(0, 0, 0, 2'b00, 2'b00);
        n_tests++;
        if (got_a() !== exp_a() || a_ovr || !a_done) begin
            n_fail++; $display("FAIL vv_in_done: got %h required %h", got_a(), exp_a());
        end
        step(0, 1, 1, 2'b10, 2'b00);
        repeat (4) step(0, 0, 0, 2'b00, 2'b00);
        n_tests++;
        if (got_a() !== exp_a() || a_cnt !== 8'd0 || !a_busy) begin
            n_fail++; $display("FAIL start_vv_same_edge: got %h required %h", got_a(), exp_a());
        end
        for (int i = 0; i < 4; i++) apply_vec(2'(i), ha(2'(i)), 3);
        step(0, 0, 0, 2'b00, 2'b00);
    endtask

    task automatic test_saturate();
        for (int run = 0; run < 2; run++) begin
            b_start = 1;
            step(0, 0, 0, 0, 0);
            b_start = 0;
            n_tests++;
            if (b_err !== 2'd0 || b_cnt !== 2'd0 || !b_busy) begin
                n_fail++; $display("FAIL sat_start_clear run%0d: got err=%0d cnt=%0d busy=%b required 0 0 1",
                                   run, b_err, b_cnt, b_busy);
            end
            for (int i = 0; i < 3; i++) begin
                b_vec = 2'(i); b_resp = ~ha(2'(i)); b_vv = 1;
                step(0, 0, 0, 0, 0);
                b_vv = 0;
                repeat (3) step(0, 0, 0, 0, 0);
            end
            n_tests++;
            if (b_err !== 2'd3 || !b_done || b_cnt !== 2'd3 || b_pass || b_fev !== 2'b00) begin
                n_fail++; $display("FAIL sat_run%0d: got err=%0d done=%b cnt=%0d pass=%b required 3 1 3 0",
                                   run, b_err, b_done, b_cnt, b_pass);
            end
        end
    endtask

    task automatic test_random();
        logic r, s, v;
        logic [1:0] vi, ri;
        int bad = 0;
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 63) == 0);
            s  = ($urandom_range(0, 11) == 0);
            v  = ($urandom_range(0, 2) == 0);
            vi = 2'($urandom_range(0, 3));
            ri = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : ha(m_pvec);
            step(r, s, v, vi, ri);
            n_tests++;
            if (got_a() !== exp_a()) begin
                n_fail++; bad++;
                if (bad <= 10) $display("FAIL random cycle %0d: got %h required %h", n, got_a(), exp_a());
            end
        end
    endtask

    initial begin
        rst = 1; start = 0; vv = 0; vec = 0; resp = 0;
        b_start = 0; b_vv = 0; b_vec = 0; b_resp = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_mismatch();
        test_overrun();
        test_midrun_reset();
        test_start_busy();
        test_same_edge();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
